// File: rtl/axil_reg_responder.sv
// AXI-Lite subordinate exposing NUM_REGS byte-strobed registers, also driven out in parallel.
// One outstanding write and one outstanding read; the two paths run independently.
module axil_reg_responder #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned LSB        = $clog2(STRB_WIDTH);
    localparam int unsigned IW         = $clog2(NUM_REGS);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP}  w_state_e;
    typedef enum logic {R_IDLE, R_VALID} r_state_e;

    w_state_e                               w_state_q, w_state_d;
    r_state_e                               r_state_q, r_state_d;
    logic                                   reset_hold_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    regs_q, regs_d;
    logic [1:0]                             bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]                  rdata_q, rdata_d;
    logic [1:0]                             rresp_q, rresp_d;

    logic                                   aw_in_range_c, ar_in_range_c;
    logic [IW-1:0]                          aw_idx_c, ar_idx_c;
    logic                                   aw_hs_c, ar_hs_c;

    // Address decode: low LSB bits ignored, anything above the register window is out of range.
    assign aw_idx_c      = awaddr[LSB +: IW];
    assign ar_idx_c      = araddr[LSB +: IW];
    assign aw_in_range_c = (awaddr >> (LSB + IW)) == '0;
    assign ar_in_range_c = (araddr >> (LSB + IW)) == '0;

    // AW and W are only ever accepted together.
    assign awready = (w_state_q == W_IDLE) && awvalid && wvalid && !reset_hold_q;
    assign wready  = awready;
    assign arready = (r_state_q == R_IDLE) && !reset_hold_q;
    assign aw_hs_c = awready;
    assign ar_hs_c = arready && arvalid;

    assign bvalid   = (w_state_q == W_RESP);
    assign bresp    = bresp_q;
    assign rvalid   = (r_state_q == R_VALID);
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign regs_out = regs_q;

    // Keeps the bus closed for the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) reset_hold_q <= 1'b1;
        else       reset_hold_q <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            regs_q    <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            regs_q    <= regs_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    w_state_d = W_RESP;
                    if (aw_in_range_c) begin
                        bresp_d = RESP_OKAY;
                        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                            if (wstrb[b]) regs_d[aw_idx_c][b*8 +: 8] = wdata[b*8 +: 8];
                        end
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read data comes from regs_q, so a same-edge write is not visible yet.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    r_state_d = R_VALID;
                    if (ar_in_range_c) begin
                        rdata_d = regs_q[ar_idx_c];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_VALID: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized self-checking bench for axil_reg_responder against a register-array model.
module tb_axil_reg_responder;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned SW = DW / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     awaddr;
    logic              awvalid, awready;
    logic [DW-1:0]     wdata;
    logic [SW-1:0]     wstrb;
    logic              wvalid, wready;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic [AW-1:0]     araddr;
    logic              arvalid, arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid, rready;
    logic [NR*DW-1:0]  regs_out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [DW-1:0] m_regs [NR];

    always #5 clk = ~clk;

    axil_reg_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_out(regs_out)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < int'(NR); i++) v[i*DW +: DW] = m_regs[i];
        return v;
    endfunction

    function automatic bit in_range(input logic [AW-1:0] a);
        return int'(a) < int'(NR * SW);
    endfunction

    function automatic int reg_idx(input logic [AW-1:0] a);
        return (int'(a) / int'(SW)) % int'(NR);
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                        input logic [SW-1:0] s);
        if (in_range(a))
            for (int b = 0; b < int'(SW); b++)
                if (s[b]) m_regs[reg_idx(a)][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // Full write transaction; bp = cycles bready is withheld once bvalid shows.
    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input int bp);
        bit hs = 0;
        int n = 0;
        logic [1:0] exp_resp;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!hs && n < 20) begin
            #1 hs = awready && wready;
            @(posedge clk);
            n++;
        end
        check_eq("aw_handshake", 128'(hs), 128'(1'b1));
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(a, d, s);
        exp_resp = in_range(a) ? 2'b00 : 2'b10;
        check_eq("bvalid_set", 128'(bvalid), 128'(1'b1));
        check_eq("bresp", 128'(bresp), 128'(exp_resp));
        check_eq("regs_out_wr", 128'(regs_out), 128'(model_flat()));
        for (int i = 0; i < bp; i++) begin
            awvalid = 1'b1; wvalid = 1'b1; awaddr = AW'($urandom);
            #1;
            check_eq("awready_bp", 128'({awready, wready}), 128'(2'b00));
            check_eq("bvalid_bp", 128'(bvalid), 128'(1'b1));
            check_eq("bresp_bp", 128'(bresp), 128'(exp_resp));
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_eq("bvalid_clr", 128'(bvalid), 128'(1'b0));
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int bp);
        bit hs = 0;
        int n = 0;
        logic [DW-1:0] exp_data;
        logic [1:0] exp_resp;
        araddr = a; arvalid = 1'b1;
        while (!hs && n < 20) begin
            #1 hs = arready;
            @(posedge clk);
            n++;
        end
        check_eq("ar_handshake", 128'(hs), 128'(1'b1));
        exp_data = in_range(a) ? m_regs[reg_idx(a)] : '0;
        exp_resp = in_range(a) ? 2'b00 : 2'b10;
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("rvalid_set", 128'(rvalid), 128'(1'b1));
        check_eq("rdata", 128'(rdata), 128'(exp_data));
        check_eq("rresp", 128'(rresp), 128'(exp_resp));
        for (int i = 0; i < bp; i++) begin
            arvalid = 1'b1; araddr = AW'($urandom);
            #1;
            check_eq("arready_bp", 128'(arready), 128'(1'b0));
            check_eq("rdata_bp", 128'(rdata), 128'(exp_data));
            check_eq("rresp_bp", 128'(rresp), 128'(exp_resp));
            @(negedge clk);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check_eq("rvalid_clr", 128'(rvalid), 128'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '1; bready = 1'b0; rready = 1'b0;
        for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;

        // Reset and the one-edge hold after release
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst_readies", 128'({awready, wready, arready}), 128'(3'b000));
        end
        check_eq("rst_outputs", 128'({bvalid, rvalid, bresp, rresp}), 128'(6'b0));
        check_eq("rst_rdata", 128'(rdata), 128'(0));
        check_eq("rst_regs", 128'(regs_out), 128'(0));
        reset = 1'b0;
        #1 check_eq("hold_readies", 128'({awready, wready, arready}), 128'(3'b000));
        @(negedge clk);
        check_eq("post_hold_readies", 128'({awready, wready, arready}), 128'(3'b111));
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("post_hold_resp", 128'({bvalid, rvalid, bresp, rresp}), 128'(6'b110000));
        check_eq("post_hold_regs", 128'(regs_out), 128'(0));
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;

        // Strobed write and read-back
        axi_write(5'h04, 32'hDEADBEEF, 4'hF, 0);
        axi_write(5'h04, 32'h00001234, 4'h3, 2);
        check_eq("strb_reg1", 128'(regs_out[63:32]), 128'(32'hDEAD1234));
        axi_read(5'h04, 0);

        // Out-of-range
        axi_write(5'h10, 32'hCAFEF00D, 4'hF, 0);
        axi_read(5'h10, 1);

        // Backpressure
        axi_write(5'h08, 32'h11223344, 4'hF, 5);
        axi_read(5'h08, 5);

        // AW without W
        awaddr = 5'h0C; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 check_eq("aw_only_ready", 128'({awready, wready}), 128'(2'b00));
            @(negedge clk);
        end
        check_eq("aw_only_regs", 128'(regs_out), 128'(model_flat()));
        wvalid = 1'b1;
        #1 check_eq("aw_w_ready", 128'({awready, wready}), 128'(2'b11));
        axi_write(5'h0C, 32'hA5A5A5A5, 4'hF, 0);

        // Same-edge write/read collision on reg 0
        axi_write(5'h00, 32'h000000AA, 4'hF, 0);
        awaddr = 5'h00; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h00; arvalid = 1'b1;
        #1 check_eq("coll_readies", 128'({awready, arready}), 128'(2'b11));
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("coll_rdata", 128'(rdata), 128'(32'hAA));
        check_eq("coll_valids", 128'({bvalid, rvalid}), 128'(2'b11));
        model_write(5'h00, 32'h00000055, 4'hF);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        axi_read(5'h00, 0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, NR * SW - 1));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, DW'($urandom), SW'($urandom), int'($urandom_range(0, 3)));
            else
                axi_read(a, int'($urandom_range(0, 3)));
        end

        // Reset while a write response is pending
        awaddr = 5'h04; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("mid_bvalid", 128'(bvalid), 128'(1'b1));
        reset = 1'b1;
        #1;
        check_eq("mid_rst_bvalid", 128'(bvalid), 128'(1'b0));
        check_eq("mid_rst_regs", 128'(regs_out), 128'(0));
        check_eq("mid_rst_arready", 128'(arready), 128'(1'b0));
        for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        axi_read(5'h04, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
